uart_tx_fifo_ctrl: RTL

Transmit-side holding controller for the 16550-compatible UART. It buffers host writes to THR in a 16-entry FIFO, or in a single holding register when FIFOs are disabled, and presents the head byte and `thre` to the serial transmitter. It consumes entries on the transmitter's `pop` handshake and generates the LSR THRE/TEMT bits and the THRE interrupt. It sits between the register-access block and the transmitter.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and sizing constants used by the TX and RX holding paths.
package uart_pkg;
   localparam int UART_FIFO_DEPTH = 16;
   localparam int UART_FIFO_AW    = 4;

   typedef logic [7:0] uart_byte_t;
   typedef logic [4:0] uart_lvl_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Circular-buffer FIFO with occupancy count and synchronous clear.
// The caller decides when push/pop are legal; clr overrides both.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FIFO_DEPTH,
   parameter int AW    = UART_FIFO_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  uart_byte_t    wdata,
   output uart_byte_t    rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   uart_byte_t          mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [AW:0]         count_q, count_d;

   // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is 2^AW
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents are not reset
   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit holding controller: FIFO/single-register holding, pop
// handshake, LSR THRE/TEMT and THRE interrupt generation.
// Optional feature macro: UART_TX_OVR_EN (sticky overflow flag tx_ovr).
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FIFO_DEPTH,
   parameter int AW    = UART_FIFO_AW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  uart_byte_t   wdata,
   input  logic         fifo_en,
   input  logic         tx_fifo_rst,
   input  logic         ier_ethre,
   input  logic         iir_rd,
   input  logic         pop,
   input  logic         sreg_empty,
   output uart_byte_t   din,
   output logic         thre,
   output logic         lsr_thre,
   output logic         lsr_temt,
   output logic         thre_irq,
   output logic [AW:0]  tx_level,
   output logic         tx_ovr
);

   logic        pop_d_q, sreg_empty_d_q, fifo_en_d_q, ier_d_q;
   logic        temt_q, temt_d;
   logic        thre_pend_q, thre_pend_d;
   logic        clear, consume, accept, at_cap, pend_set, pend_clr;
   logic [AW:0] count;
   logic        full, empty;

   uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .push  (accept),
      .pop   (consume),
      .wdata (wdata),
      .rdata (din),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Edge detection, capacity select and write acceptance
   always_comb begin
      clear    = tx_fifo_rst | (fifo_en ^ fifo_en_d_q);
      at_cap   = fifo_en ? full : ~empty;
      consume  = pop & ~pop_d_q & ~empty;
      // A write is dropped only when at capacity with no consume in the same edge
      accept   = wr & ~clear & (~at_cap | consume);
      pend_set = clear
               | (consume & (count == (AW+1)'(1)) & ~accept)
               | (ier_ethre & ~ier_d_q & empty);
      pend_clr = accept | iir_rd;
   end

   // TEMT and THRE-pending next state; pending clear wins over set
   always_comb begin
      temt_d = temt_q;
      if (consume)
         temt_d = 1'b0;
      else if (sreg_empty && !sreg_empty_d_q && empty && !accept)
         temt_d = 1'b1;
      thre_pend_d = thre_pend_q;
      if (pend_clr)      thre_pend_d = 1'b0;
      else if (pend_set) thre_pend_d = 1'b1;
   end

   // Registered input copies and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_d_q        <= 1'b0;
         sreg_empty_d_q <= 1'b0;
         fifo_en_d_q    <= 1'b0;
         ier_d_q        <= 1'b0;
         temt_q         <= 1'b1;
         thre_pend_q    <= 1'b0;
      end else begin
         pop_d_q        <= pop;
         sreg_empty_d_q <= sreg_empty;
         fifo_en_d_q    <= fifo_en;
         ier_d_q        <= ier_ethre;
         temt_q         <= temt_d;
         thre_pend_q    <= thre_pend_d;
      end
   end

`ifdef UART_TX_OVR_EN
   logic tx_ovr_q, tx_ovr_d;

   // Sticky overflow: set on a dropped write, cleared by any clear event
   always_comb begin
      tx_ovr_d = tx_ovr_q;
      if (clear)              tx_ovr_d = 1'b0;
      else if (wr && !accept) tx_ovr_d = 1'b1;
   end

   // Overflow flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_ovr_q <= 1'b0;
      else     tx_ovr_q <= tx_ovr_d;
   end

   assign tx_ovr = tx_ovr_q;
`else
   assign tx_ovr = 1'b0;
`endif

   assign thre     = empty;
   assign lsr_thre = empty;
   assign lsr_temt = temt_q & empty;
   // Enable taken from its registered copy so the IRQ has no input-to-output path
   assign thre_irq = thre_pend_q & ier_d_q;
   assign tx_level = count;

endmodule
